// File: rtl/fft_r22sdf_bitrev_pkg.sv
// Shared definitions for the R2^2 SDF FFT output reorder stage: read FSM states and bit reversal.
package fft_r22sdf_bitrev_pkg;

    localparam int MAX_NLOG2 = 16;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    // Mirrors the low nbits of v; bits above nbits come back as zero.
    function automatic logic [MAX_NLOG2-1:0] bitrev(input logic [MAX_NLOG2-1:0] v, input int nbits);
        logic [MAX_NLOG2-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_NLOG2; i++) begin
            if (i < nbits) begin
                r[i] = v[nbits-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_r22sdf_bitrev_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port; array contents are never reset.
module fft_r22sdf_bitrev_ram #(
    parameter int DATA_W = 50,
    parameter int ADDR_W = 11
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset so the data outputs come up at zero.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_r22sdf_bitrev.sv
// Ping-pong bit-reversal reorder buffer after the last R2^2 SDF butterfly stage.
// Optional feature: define FFT_BITREV_LAST_EN to add the last_o end-of-frame marker.
module fft_r22sdf_bitrev
    import fft_r22sdf_bitrev_pkg::*;
#(
    parameter int DATA_WIDTH = 25,
    parameter int FFT_N      = 1024,
    parameter int FFT_NLOG2  = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_n,
    input  logic                        valid_i,
    input  logic signed [DATA_WIDTH-1:0] x_re_i,
    input  logic signed [DATA_WIDTH-1:0] x_im_i,
    output logic                        valid_o,
    output logic [FFT_NLOG2-1:0]        cnt_o,
    output logic signed [DATA_WIDTH-1:0] z_re_o,
    output logic signed [DATA_WIDTH-1:0] z_im_o,
    output logic                        overrun_o
`ifdef FFT_BITREV_LAST_EN
    ,
    output logic                        last_o
`endif
);

    localparam logic [FFT_NLOG2-1:0] CNT_MAX = FFT_NLOG2'(FFT_N - 1);

    logic [FFT_NLOG2-1:0]    wr_cnt;
    logic [FFT_NLOG2-1:0]    rd_cnt;
    logic                    wr_bank;
    logic                    rd_bank;
    logic                    start_bank;
    logic [1:0]              full;
    logic [1:0]              full_nxt;
    rd_state_e               rd_state;
    rd_state_e               rd_state_nxt;
    logic                    wr_last;
    logic                    issue;
    logic                    rd_last;
    logic [FFT_NLOG2-1:0]    wr_addr_lo;
    logic [2*DATA_WIDTH-1:0] rdata;

    assign wr_last    = valid_i && (wr_cnt == CNT_MAX);
    assign issue      = (rd_state == RD_READ);
    assign rd_last    = issue && (rd_cnt == CNT_MAX);
    assign wr_addr_lo = FFT_NLOG2'(bitrev(MAX_NLOG2'(wr_cnt), FFT_NLOG2));

    // With both banks full the one about to be rewritten is the older, so it is read first.
    always_comb begin
        rd_state_nxt = rd_state;
        start_bank   = full[wr_bank] ? wr_bank : ~wr_bank;
        full_nxt     = full;
        if (issue && (rd_cnt == '0)) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
        case (rd_state)
            RD_IDLE: if (|full) rd_state_nxt = RD_READ;
            RD_READ: if (rd_last && !full[~rd_bank]) rd_state_nxt = RD_IDLE;
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
        end else begin
            rd_state <= rd_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            full      <= '0;
            overrun_o <= 1'b0;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
        end else begin
            full <= full_nxt;
            if (valid_i) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (wr_last) begin
                wr_bank <= ~wr_bank;
                if (full[~wr_bank]) begin
                    overrun_o <= 1'b1;
                end
            end
            if (issue) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if ((rd_state == RD_IDLE) && (|full)) begin
                rd_bank <= start_bank;
            end else if (rd_last) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Output strobes trail the issued address by one cycle, matching the registered RAM read.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            cnt_o   <= '0;
        end else begin
            valid_o <= issue;
            if (issue) begin
                cnt_o <= rd_cnt;
            end
        end
    end

`ifdef FFT_BITREV_LAST_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            last_o <= 1'b0;
        end else begin
            last_o <= rd_last;
        end
    end
`endif

    fft_r22sdf_bitrev_ram #(
        .DATA_W (2 * DATA_WIDTH),
        .ADDR_W (FFT_NLOG2 + 1)
    ) u_ram (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .we    (valid_i),
        .waddr ({wr_bank, wr_addr_lo}),
        .wdata ({x_re_i, x_im_i}),
        .re    (issue),
        .raddr ({rd_bank, rd_cnt}),
        .rdata (rdata)
    );

    assign z_re_o = rdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign z_im_o = rdata[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fft_r22sdf_bitrev.sv
// Self-checking bench for fft_r22sdf_bitrev at FFT_N=16 against a frame-level reorder model.
module tb_fft_r22sdf_bitrev;
    import fft_r22sdf_bitrev_pkg::*;

    localparam int DW = 25;
    localparam int N  = 16;
    localparam int LG = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_n;
    logic                 valid_i;
    logic signed [DW-1:0] x_re_i;
    logic signed [DW-1:0] x_im_i;
    logic                 valid_o;
    logic [LG-1:0]        cnt_o;
    logic signed [DW-1:0] z_re_o;
    logic signed [DW-1:0] z_im_o;
    logic                 overrun_o;
`ifdef FFT_BITREV_LAST_EN
    logic                 last_o;
`endif

    fft_r22sdf_bitrev #(
        .DATA_WIDTH (DW),
        .FFT_N      (N),
        .FFT_NLOG2  (LG)
    ) dut (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .valid_i   (valid_i),
        .x_re_i    (x_re_i),
        .x_im_i    (x_im_i),
        .valid_o   (valid_o),
        .cnt_o     (cnt_o),
        .z_re_o    (z_re_o),
        .z_im_o    (z_im_o),
        .overrun_o (overrun_o)
`ifdef FFT_BITREV_LAST_EN
        ,
        .last_o    (last_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        int            cnt;
        int            at;
    } exp_t;

    int            vectors    = 0;
    int            miscompares = 0;
    int            cyc        = 0;
    int            sched_end  = 0;
    bit            mon_en     = 1'b1;
    exp_t          expq[$];
    logic [DW-1:0] in_re[$];
    logic [DW-1:0] in_im[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic int refBitrev(input int v);
        int r = 0;
        for (int b = 0; b < LG; b++) begin
            r = (r << 1) | ((v >> b) & 1);
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, want);
        end
    endtask

    // A completed input frame is read back as out[n] = arrival[bitrev(n)], queued behind any earlier frame.
    task automatic scheduleFrame();
        int   start;
        exp_t e;
        start = (cyc + 3 > sched_end) ? cyc + 3 : sched_end;
        for (int n = 0; n < N; n++) begin
            e.re  = in_re[refBitrev(n)];
            e.im  = in_im[refBitrev(n)];
            e.cnt = n;
            e.at  = start + n;
            expq.push_back(e);
        end
        sched_end = start + N;
        in_re.delete();
        in_im.delete();
    endtask

    always @(negedge clk_i) begin
        if (!rst_n) begin
            in_re.delete();
            in_im.delete();
            expq.delete();
            sched_end = 0;
            if (mon_en) begin
                checkOutput("reset_valid", 64'(valid_o), 64'd0);
                checkOutput("reset_cnt", 64'(cnt_o), 64'd0);
                checkOutput("reset_re", 64'($unsigned(z_re_o)), 64'd0);
                checkOutput("reset_im", 64'($unsigned(z_im_o)), 64'd0);
                checkOutput("reset_overrun", 64'(overrun_o), 64'd0);
            end
        end else if (mon_en) begin
            if (expq.size() > 0 && expq[0].at == cyc) begin
                checkOutput("valid", 64'(valid_o), 64'd1);
                checkOutput("cnt", 64'(cnt_o), 64'(expq[0].cnt));
                checkOutput("z_re", 64'($unsigned(z_re_o)), 64'(expq[0].re));
                checkOutput("z_im", 64'($unsigned(z_im_o)), 64'(expq[0].im));
`ifdef FFT_BITREV_LAST_EN
                checkOutput("last", 64'(last_o), 64'(expq[0].cnt == N - 1));
`endif
                void'(expq.pop_front());
            end else begin
                checkOutput("idle_valid", 64'(valid_o), 64'd0);
`ifdef FFT_BITREV_LAST_EN
                checkOutput("idle_last", 64'(last_o), 64'd0);
`endif
            end
            checkOutput("overrun", 64'(overrun_o), 64'd0);
            if (valid_i) begin
                in_re.push_back($unsigned(x_re_i));
                in_im.push_back($unsigned(x_im_i));
                if (in_re.size() == N) begin
                    scheduleFrame();
                end
            end
        end
    end

    task automatic applyStimulus(input bit v, input logic [DW-1:0] re, input logic [DW-1:0] im);
        @(posedge clk_i);
        #1;
        valid_i = v;
        x_re_i  = re;
        x_im_i  = im;
    endtask

    // mode 0: ramp data re=bitrev(k), im=-bitrev(k); mode 1: random data.
    // gaps 0: none; 1: one idle cycle before every sample; 2: random idles.
    task automatic sendFrame(input int mode, input int gaps, input int count);
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        for (int k = 0; k < count; k++) begin
            if (gaps == 1 || (gaps == 2 && $urandom_range(0, 3) == 0)) begin
                applyStimulus(1'b0, DW'($urandom), DW'($urandom));
            end
            if (mode == 0) begin
                re = DW'(refBitrev(k));
                im = DW'(-refBitrev(k));
            end else begin
                re = DW'($urandom);
                im = DW'($urandom);
            end
            applyStimulus(1'b1, re, im);
        end
    endtask

    task automatic drain();
        applyStimulus(1'b0, '0, '0);
        for (int i = 0; i < 6 * N && expq.size() > 0; i++) begin
            @(negedge clk_i);
        end
        repeat (4) @(negedge clk_i);
        checkOutput("drain_pending", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        x_re_i  = '0;
        x_im_i  = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_n = 1'b1;

        $display("[TB] single frame, ramp data");
        sendFrame(0, 0, N);
        drain();

        $display("[TB] three back-to-back frames");
        sendFrame(1, 0, 3 * N);
        drain();

        $display("[TB] alternate-cycle input frame");
        sendFrame(0, 1, N);
        drain();

        $display("[TB] reset after nine samples");
        sendFrame(1, 0, 9);
        @(posedge clk_i);
        #1;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_n = 1'b1;
        sendFrame(0, 0, N);
        drain();

        $display("[TB] randomly gapped frames");
        for (int f = 0; f < 5; f++) begin
            sendFrame(1, 2, N);
        end
        drain();

        $display("[TB] read stall forcing overrun");
        mon_en = 1'b0;
        force dut.rd_state = RD_IDLE;
        sendFrame(1, 0, N);
        applyStimulus(1'b0, '0, '0);
        repeat (2) @(negedge clk_i);
        checkOutput("stall_overrun_f1", 64'(overrun_o), 64'd0);
        checkOutput("stall_valid_f1", 64'(valid_o), 64'd0);
        sendFrame(1, 0, 2 * N);
        applyStimulus(1'b0, '0, '0);
        repeat (2) @(negedge clk_i);
        checkOutput("stall_overrun_f3", 64'(overrun_o), 64'd1);
        repeat (6) @(negedge clk_i);
        checkOutput("stall_overrun_sticky", 64'(overrun_o), 64'd1);
        checkOutput("stall_valid_f3", 64'(valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_n = 1'b0;
        release dut.rd_state;
        @(negedge clk_i);
        checkOutput("post_stall_reset_overrun", 64'(overrun_o), 64'd0);
        checkOutput("post_stall_reset_valid", 64'(valid_o), 64'd0);
        mon_en = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_n = 1'b1;

        $display("[TB] frames after recovery");
        sendFrame(1, 0, 2 * N);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
